// File: rtl/sin_rom.sv
// sin_rom: two-stage synchronous sine lookup for the DDS path.
// The top 10 phase bits select one of 1024 points per period; a 257-entry
// quarter-wave table plus quadrant symmetry rebuilds the full wave.
// Optional build macro: SINROM_SIGNED_OUT_EN selects a two's complement
// output (+m / -m, mid-scale 16'h0000). When it is undefined, the output
// is offset binary (32768 +/- m, mid-scale 16'h8000).
// Interface: there is no handshake. A new address is accepted on every
// rising edge, and its sample appears on q exactly two rising edges later.
module sin_rom #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16   // only 16 is supported
) (
  input  logic              clock,
  input  logic              reset,    // asynchronous, active-low
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q
);

  localparam int TAB_N = 257;

`ifdef SINROM_SIGNED_OUT_EN
  localparam logic [DATA_W-1:0] LP_MID = 16'h0000;
`else
  localparam logic [DATA_W-1:0] LP_MID = 16'h8000;
`endif

  // Quarter-wave sample k: round(32767*sin(2*pi*k/1024)). It is evaluated
  // only at elaboration, so each table entry is a plain constant.
  function automatic logic [15:0] quarter_sin(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return 16'($rtoi(r + 0.5));
  endfunction

  logic [15:0] w_qtab [0:TAB_N-1];

  for (genvar g = 0; g < TAB_N; g++) begin : g_tab
    localparam logic [15:0] LP_Q = quarter_sin(g);
    assign w_qtab[g] = LP_Q;
  end

  // Phase decode: idx = top 10 bits, quad = idx[9:8], p = idx[7:0].
  logic [9:0] w_idx;
  logic [1:0] w_quad;
  logic [7:0] w_p;
  logic [8:0] w_k;
  logic       w_unused_low;

  assign w_idx  = address[ADDR_W-1 -: 10];
  assign w_quad = w_idx[9:8];
  assign w_p    = w_idx[7:0];
  // Odd quadrants run the table backwards. p = 0 in quadrant 1 or 3 lands
  // on k = 256, the peak entry.
  assign w_k    = w_quad[0] ? (9'd256 - {1'b0, w_p}) : {1'b0, w_p};
  // The low phase bits carry no information for this lookup.
  assign w_unused_low = ^address[ADDR_W-11:0];

  logic [8:0] r_k;
  logic       r_sign;

  // Stage 1: register the table index and the half-wave sign.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_k    <= 9'd0;
      r_sign <= 1'b0;
    end else begin
      r_k    <= w_k;
      r_sign <= w_quad[1];
    end
  end

  logic [15:0]       w_mag;
  logic [DATA_W-1:0] w_q_next;

  assign w_mag = w_qtab[r_k];

`ifdef SINROM_SIGNED_OUT_EN
  assign w_q_next = r_sign ? (16'h0000 - w_mag) : w_mag;
`else
  // The magnitude is at most 32767, so both results stay within 1..65535.
  assign w_q_next = r_sign ? (16'h8000 - w_mag) : (16'h8000 + w_mag);
`endif

  logic [DATA_W-1:0] r_q;

  // Stage 2: register the looked-up and offset sample. Reset parks q at
  // mid-scale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= LP_MID;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_sin_rom.sv
// tb_sin_rom: scoreboard bench for sin_rom using directed phase vectors.
// Expected samples are hand-computed offset-binary constants. They are
// converted to two's complement when SINROM_SIGNED_OUT_EN is defined.
module tb_sin_rom;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] q;

  always #5 clock = ~clock;

  sin_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .q       (q)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          chk_q[$];
  int          idx_q[$];
  logic        vld_in = 1'b0;
  logic        v1, v2;
  logic [16:0] obs [0:1023];

`ifdef SINROM_SIGNED_OUT_EN
  localparam logic [15:0] MID = 16'h0000;
  function automatic logic [15:0] enc(input int ob);
    return 16'(ob - 32768);
  endfunction
  function automatic logic [16:0] dec(input logic [15:0] v);
    return {1'b0, v + 16'h8000};
  endfunction
`else
  localparam logic [15:0] MID = 16'h8000;
  function automatic logic [15:0] enc(input int ob);
    return 16'(ob);
  endfunction
  function automatic logic [16:0] dec(input logic [15:0] v);
    return {1'b0, v};
  endfunction
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [9:0] idx, input logic [12:0] low,
                       input int exp_ob, input bit chk);
    @(negedge clock);
    address = {idx, low};
    vld_in  = 1'b1;
    exp_q.push_back(enc(exp_ob));
    chk_q.push_back(chk);
    idx_q.push_back(int'(idx));
  endtask

  task automatic idle();
    @(negedge clock);
    vld_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      chk_q.delete();
      idx_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  // The valid tag travels two stages, matching the fixed DUT latency.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= vld_in;
      v2 <= v1;
    end
  end

  always @(posedge clock) begin : mon
    logic [15:0] e;
    bit          c;
    int          i;
    #1;
    if (v2 && reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got output 0x%h expected none", q);
      end else begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        i = idx_q.pop_front();
        if (c) check($sformatf("idx%0d", i), q, e);
        else   obs[i] = dec(q);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    address = 23'($urandom_range(0, 23'h7FFFFF));
    #2 reset = 1'b0;
    #1 check("reset_async", q, MID);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Quadrant points
    drive(10'd0,   13'd0, 32768, 1'b1);
    drive(10'd256, 13'd0, 65535, 1'b1);
    drive(10'd512, 13'd0, 32768, 1'b1);
    drive(10'd768, 13'd0, 1,     1'b1);
    // Octant points
    drive(10'd128, 13'd0, 55938, 1'b1);
    drive(10'd384, 13'd0, 55938, 1'b1);
    drive(10'd640, 13'd0, 9598,  1'b1);
    drive(10'd896, 13'd0, 9598,  1'b1);
    // Low-bit insensitivity
    drive(10'd256, 13'h1FFF, 65535, 1'b1);
    drive(10'd256, 13'h0000, 65535, 1'b1);
    drive(10'd128, 13'($urandom_range(0, 8191)), 55938, 1'b1);
    // Back-to-back stream across the period wrap and the quadrant-1 peak
    drive(10'd1021, 13'd0, 32165, 1'b1);
    drive(10'd1022, 13'd0, 32366, 1'b1);
    drive(10'd1023, 13'd0, 32567, 1'b1);
    drive(10'd0,    13'd0, 32768, 1'b1);
    drive(10'd1,    13'd0, 32969, 1'b1);
    drive(10'd2,    13'd0, 33170, 1'b1);
    drive(10'd3,    13'd0, 33371, 1'b1);
    drive(10'd255,  13'd0, 65534, 1'b1);
    drive(10'd256,  13'd0, 65535, 1'b1);
    drive(10'd257,  13'd0, 65534, 1'b1);
    idle();
    drain();

    // Mid-stream reset: in-flight samples are dropped and q snaps to mid-scale
    drive(10'd256, 13'd0, 65535, 1'b1);
    drive(10'd257, 13'd0, 65534, 1'b1);
    drive(10'd768, 13'd0, 1,     1'b1);
    #2;
    vld_in = 1'b0;
    reset  = 1'b0;
    #1 check("reset_midstream", q, MID);
    exp_q.delete();
    chk_q.delete();
    idx_q.delete();
    @(negedge clock);
    address = {10'd256, 13'd0};
    reset   = 1'b1;
    @(posedge clock);
    #1 check("reset_release_1edge", q, MID);
    drive(10'd768, 13'd0, 1,     1'b1);
    drive(10'd0,   13'd0, 32768, 1'b1);
    drive(10'd256, 13'd0, 65535, 1'b1);
    idle();
    drain();

    // Full sweep with random low bits, then check symmetry and monotonicity
    for (int i = 0; i < 1024; i++)
      drive(10'(i), 13'($urandom_range(0, 8191)), 0, 1'b0);
    idle();
    drain();
    for (int i = 0; i < 512; i++)
      check_int($sformatf("sym%0d", i), int'(obs[i]) + int'(obs[i+512]), 65536);
    for (int i = 0; i < 256; i++)
      check_int($sformatf("mono%0d", i), int'(obs[i+1] >= obs[i]), 1);
    check_int("sweep_wrap", int'(obs[1023]), 32567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
